// File: rtl/geofence_driver.sv
// geofence_driver: loads point/fence test cases, streams them into a geofence
// receiver, and scores the receiver's valid/is_inside answers.
// Optional build macro GEOFENCE_DRV_TIMEOUT_EN adds a bounded wait for valid;
// a timed-out case counts as a failure and the receiver is reset again.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a start with a legal num_cases; X/Y held at 0
// S_RST_DUT | one-cycle dut_rst pulse to realign the receiver
// S_SEND    | seven cycles driving point k (object, then six vertices)
// S_WAIT    | waiting for the receiver's valid; scores the answer
// S_DONE    | one-cycle done pulse, then back to idle
module geofence_driver #(
    parameter int MAX_CASES = 16,
    parameter int CASE_W    = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CASE_W-1:0] wr_case,
    input  logic [2:0]        wr_pt,
    input  logic [19:0]       wr_xy,
    input  logic              wr_exp,
    input  logic [CASE_W:0]   num_cases,
    input  logic              start,
    output logic [9:0]        X,
    output logic [9:0]        Y,
    output logic              dut_rst,
    input  logic              valid,
    input  logic              is_inside,
    output logic              busy,
    output logic              done,
    output logic [CASE_W:0]   pass_cnt,
    output logic [CASE_W:0]   fail_cnt,
    output logic [CASE_W-1:0] first_fail
);

    // Catch parameter sets that cannot index the case store or never time out.
    if (MAX_CASES > (1 << CASE_W) || TIMEOUT < 1) begin : g_bad_params
        $error("geofence_driver: illegal MAX_CASES/CASE_W/TIMEOUT combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CASE_W:0] MAX_N = (CASE_W+1)'(MAX_CASES);
    localparam logic [2:0]      LAST_PT = 3'd6;

    state_t              state_q, state_d;
    logic [CASE_W-1:0]   c_q, c_d;
    logic [2:0]          k_q, k_d;
    logic [CASE_W:0]     num_q, num_d;
    logic [CASE_W:0]     pass_q, pass_d;
    logic [CASE_W:0]     fail_q, fail_d;
    logic [CASE_W-1:0]   ff_q, ff_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic                dut_rst_q, dut_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                num_ok;
    logic                last_case;
    logic                case_end;
    logic                fail_hit;
    logic                goto_rst;

`ifdef GEOFENCE_DRV_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [WAIT_W-1:0]   wait_inc;
`endif

    // Case store: point 0 is the object, 1..6 the fence; never cleared by reset.
    logic [19:0]         mem_xy  [MAX_CASES][7];
    logic                mem_exp [MAX_CASES];

    assign num_ok    = (num_cases != '0) && (num_cases <= MAX_N);
    assign last_case = ({1'b0, c_q} == (num_q - (CASE_W+1)'(1)));

    // Case-memory writes, accepted in every state; point index 7 is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_pt != 3'd7) && ({1'b0, wr_case} < MAX_N)) begin
            mem_xy[wr_case][wr_pt] <= wr_xy;
            if (wr_pt == 3'd0) begin
                mem_exp[wr_case] <= wr_exp;
            end
        end
    end

    // Next-state, case/point sequencing and scoring.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        k_d      = k_q;
        num_d    = num_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ff_d     = ff_q;
        case_end = 1'b0;
        fail_hit = 1'b0;
        goto_rst = 1'b0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
        wait_d   = wait_q;
        wait_inc = wait_q + WAIT_W'(1);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && num_ok) begin
                    state_d = S_RST_DUT;
                    c_d     = '0;
                    num_d   = num_cases;
                    pass_d  = '0;
                    fail_d  = '0;
                    ff_d    = '0;
                end
            end
            S_RST_DUT: begin
                state_d = S_SEND;
                k_d     = 3'd0;
            end
            S_SEND: begin
                if (k_q == LAST_PT) begin
                    state_d = S_WAIT;
                    k_d     = 3'd0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (valid) begin
                    case_end = 1'b1;
                    if (is_inside == mem_exp[c_q]) begin
                        pass_d = pass_q + (CASE_W+1)'(1);
                    end else begin
                        fail_hit = 1'b1;
                    end
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                end else if (wait_inc == WAIT_LIMIT) begin
                    // Receiver may be wedged: score a fail and reset it again.
                    case_end = 1'b1;
                    fail_hit = 1'b1;
                    goto_rst = 1'b1;
                end else begin
                    wait_d = wait_inc;
`endif
                end
                if (fail_hit) begin
                    fail_d = fail_q + (CASE_W+1)'(1);
                    if (fail_q == '0) begin
                        ff_d = c_q;
                    end
                end
                if (case_end) begin
                    if (last_case) begin
                        state_d = S_DONE;
                    end else begin
                        // Receiver returns to its load state one cycle after
                        // valid, so the next object goes out immediately.
                        c_d     = c_q + CASE_W'(1);
                        k_d     = 3'd0;
                        state_d = goto_rst ? S_RST_DUT : S_SEND;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        x_d       = '0;
        y_d       = '0;
        if (state_d == S_SEND) begin
            {x_d, y_d} = mem_xy[c_d][k_d];
        end
        dut_rst_d = (state_d == S_RST_DUT);
        busy_d    = (state_d == S_RST_DUT) || (state_d == S_SEND) || (state_d == S_WAIT);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            c_q       <= '0;
            k_q       <= '0;
            num_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            ff_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            k_q       <= k_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ff_q      <= ff_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef GEOFENCE_DRV_TIMEOUT_EN
    // Cycles spent in WAIT for the current case.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign X          = x_q;
    assign Y          = y_q;
    assign dut_rst    = dut_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: a scripted receiver answers each case; streamed
// points are checked against a scoreboard queue filled when a run starts.
module tb_geofence_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_case = '0;
    logic [2:0]  wr_pt = '0;
    logic [19:0] wr_xy = '0;
    logic        wr_exp = 1'b0;
    logic [4:0]  num_cases = '0;
    logic        start = 1'b0;
    logic [9:0]  X, Y;
    logic        dut_rst;
    logic        valid = 1'b0;
    logic        is_inside = 1'b0;
    logic        busy, done;
    logic [4:0]  pass_cnt, fail_cnt;
    logic [3:0]  first_fail;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int rst_pulses = 0;

    logic [19:0] m_xy [16][7];
    bit          m_exp [16];
    bit          ans [16];
    logic [19:0] sb_q [$];

    int lp = 0, lf = 0, lff = 0;

    geofence_driver dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_case(wr_case), .wr_pt(wr_pt),
        .wr_xy(wr_xy), .wr_exp(wr_exp), .num_cases(num_cases), .start(start),
        .X(X), .Y(Y), .dut_rst(dut_rst), .valid(valid), .is_inside(is_inside),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut_rst === 1'b1) rst_pulses++;

    task automatic wr_point(input int cs, input int pt, input logic [19:0] xy, input bit e);
        @(negedge clk);
        wr_en = 1'b1; wr_case = cs[3:0]; wr_pt = pt[2:0]; wr_xy = xy; wr_exp = e;
        @(negedge clk);
        wr_en = 1'b0;
        if (pt < 7) begin
            m_xy[cs][pt] = xy;
            if (pt == 0) m_exp[cs] = e;
        end
    endtask

    // Hexagon around (500,500) shifted right by sh; vertex writes carry ~e
    // on wr_exp to show only point 0 stores the expected bit.
    task automatic load_case(input int cs, input int ox, input int oy, input bit e, input int sh);
        int vx[6] = '{600, 550, 450, 400, 450, 550};
        int vy[6] = '{500, 587, 587, 500, 413, 413};
        wr_point(cs, 0, {ox[9:0], oy[9:0]}, e);
        for (int i = 0; i < 6; i++) begin
            int px;
            px = vx[i] + sh;
            wr_point(cs, i + 1, {px[9:0], vy[i][9:0]}, ~e);
        end
        wr_point(cs, 7, 20'hFFFFF, ~e);
    endtask

    task automatic check_idle_zero(input string nm);
        vec_cnt++;
        if ({X, Y, dut_rst, busy, done, pass_cnt, fail_cnt, first_fail} !== '0) begin
            miss_cnt++;
            $display("FAIL %s: got X=%0d Y=%0d rst=%b busy=%b done=%b pass=%0d fail=%0d ff=%0d, required all 0",
                     nm, X, Y, dut_rst, busy, done, pass_cnt, fail_cnt, first_fail);
        end
    endtask

    // Runs n cases; receiver answers ans[c] after dly WAIT cycles (dly >= 1).
    // inject: valid and start pulsed mid-SEND of case 0. abort_c: reset
    // asserted in WAIT of that case instead of answering.
    task automatic do_run(input int n, input int dly, input bit inject, input int abort_c);
        int ep, ef, eff, r0;
        logic [19:0] e;
        ep = 0; ef = 0; eff = 0;
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 7; k++) sb_q.push_back(m_xy[i][k]);
            if (ans[i] == m_exp[i]) ep++;
            else begin
                if (ef == 0) eff = i;
                ef++;
            end
        end
        r0 = rst_pulses;
        @(negedge clk);
        num_cases = 5'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vec_cnt++;
        if (dut_rst !== 1'b1 || busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL run_start: got dut_rst=%b busy=%b, required 1 1", dut_rst, busy);
        end
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 7; k++) begin
                if (!(c > 0 && k == 0)) @(negedge clk);
                valid = 1'b0; start = 1'b0;
                e = sb_q.pop_front();
                vec_cnt++;
                if ({X, Y} !== e) begin
                    miss_cnt++;
                    $display("FAIL point c%0d k%0d: got (%0d,%0d), required (%0d,%0d)",
                             c, k, X, Y, e[19:10], e[9:0]);
                end
                if (inject && c == 0 && k == 3) begin
                    valid = 1'b1; is_inside = ~ans[0]; start = 1'b1;
                end
            end
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                vec_cnt++;
                if ({X, Y} !== 20'd0 || busy !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL wait_xy c%0d: got (%0d,%0d) busy=%b, required (0,0) busy=1",
                             c, X, Y, busy);
                end
            end
            if (c == abort_c) begin
                reset = 1'b0;
                @(negedge clk);
                check_idle_zero("abort_reset");
                reset = 1'b1;
                sb_q.delete();
                lp = 0; lf = 0; lff = 0;
                return;
            end
            valid = 1'b1; is_inside = ans[c];
            @(negedge clk);
            valid = 1'b0;
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL done_pulse: got done=%b busy=%b, required 1 0", done, busy);
        end
        vec_cnt++;
        if (pass_cnt !== 5'(ep) || fail_cnt !== 5'(ef) || first_fail !== 4'(eff)) begin
            miss_cnt++;
            $display("FAIL score: got pass=%0d fail=%0d ff=%0d, required %0d %0d %0d",
                     pass_cnt, fail_cnt, first_fail, ep, ef, eff);
        end
        vec_cnt++;
        if (rst_pulses - r0 !== 1) begin
            miss_cnt++;
            $display("FAIL dut_rst_count: got %0d, required 1", rst_pulses - r0);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || pass_cnt !== 5'(ep) || fail_cnt !== 5'(ef)) begin
            miss_cnt++;
            $display("FAIL after_done: got done=%b busy=%b pass=%0d fail=%0d, required 0 0 %0d %0d",
                     done, busy, pass_cnt, fail_cnt, ep, ef);
        end
        lp = ep; lf = ef; lff = eff;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset_idle");
    endtask

    task automatic test_single_pass();
        load_case(0, 500, 500, 1'b1, 0);
        ans[0] = 1'b1;
        do_run(1, 3, 1'b0, -1);
    endtask

    task automatic test_single_fail();
        load_case(0, 0, 0, 1'b1, 0);
        ans[0] = 1'b0;
        do_run(1, 2, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        load_case(0, 500, 500, 1'b1, 0);
        load_case(1, 100, 900, 1'b0, 7);
        load_case(2, 520, 480, 1'b1, 21);
        ans[0] = 1'b1; ans[1] = 1'b0; ans[2] = 1'b1;
        do_run(3, 1, 1'b0, -1);
        ans[1] = 1'b1;
        do_run(3, 4, 1'b0, -1);
    endtask

    task automatic test_ignored_inputs();
        ans[0] = 1'b1; ans[1] = 1'b1;
        do_run(2, 2, 1'b1, -1);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            num_cases = (t == 0) ? 5'd0 : 5'd17;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) begin
                @(negedge clk);
                vec_cnt++;
                if (busy !== 1'b0 || dut_rst !== 1'b0 || pass_cnt !== 5'(lp) ||
                    fail_cnt !== 5'(lf) || first_fail !== 4'(lff)) begin
                    miss_cnt++;
                    $display("FAIL bad_num_start n=%0d: got busy=%b rst=%b pass=%0d fail=%0d ff=%0d, required 0 0 %0d %0d %0d",
                             num_cases, busy, dut_rst, pass_cnt, fail_cnt, first_fail, lp, lf, lff);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        ans[0] = 1'b1; ans[1] = 1'b0; ans[2] = 1'b0;
        do_run(3, 2, 1'b0, 1);
        @(negedge clk);
        check_idle_zero("abort_hold");
        do_run(3, 2, 1'b0, -1);
    endtask

`ifdef GEOFENCE_DRV_TIMEOUT_EN
    task automatic test_timeout();
        load_case(0, 500, 500, 1'b1, 0);
        load_case(1, 0, 0, 1'b0, 3);
        @(negedge clk);
        num_cases = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                vec_cnt++;
                if ({X, Y} !== m_xy[c][k]) begin
                    miss_cnt++;
                    $display("FAIL to_point c%0d k%0d: got %h, required %h", c, k, {X, Y}, m_xy[c][k]);
                end
            end
            if (c == 0) begin
                repeat (64) begin
                    @(negedge clk);
                    vec_cnt++;
                    if (dut_rst !== 1'b0 || fail_cnt !== 5'd0) begin
                        miss_cnt++;
                        $display("FAIL to_early: got rst=%b fail=%0d, required 0 0", dut_rst, fail_cnt);
                    end
                end
                @(negedge clk);
                vec_cnt++;
                if (dut_rst !== 1'b1 || fail_cnt !== 5'd1 || first_fail !== 4'd0) begin
                    miss_cnt++;
                    $display("FAIL to_expire: got rst=%b fail=%0d ff=%0d, required 1 1 0",
                             dut_rst, fail_cnt, first_fail);
                end
            end
        end
        @(negedge clk);
        valid = 1'b1; is_inside = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        vec_cnt++;
        if (done !== 1'b1 || pass_cnt !== 5'd1 || fail_cnt !== 5'd1) begin
            miss_cnt++;
            $display("FAIL to_final: got done=%b pass=%0d fail=%0d, required 1 1 1", done, pass_cnt, fail_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_single_fail();
        test_back_to_back();
        test_ignored_inputs();
        test_reset_mid_run();
`ifdef GEOFENCE_DRV_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/geofence_driver.md
Name: geofence_driver

Overview:
- Transmitter/checker for the geofence X/Y point-stream protocol.
- Holds up to MAX_CASES test cases, each one object point plus six fence vertices and an expected is_inside bit.
- Streams each case into a geofence receiver, captures the valid/is_inside response and scores it against the expected bit.
- Sits beside the receiver in integration and self-test benches; drives the receiver's reset so both blocks start aligned.

Parameters:
- MAX_CASES, 16, case storage depth.
- CASE_W, 4, case index width; 2**CASE_W >= MAX_CASES.
- TIMEOUT, 64, maximum wait in cycles for valid. Used only with GEOFENCE_DRV_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  case-memory write strobe.
- wr_case  in  CASE_W  case index to write.
- wr_pt  in  3  point index: 0 = object, 1..6 = fence vertices; 7 is ignored.
- wr_xy  in  20  {X[9:0], Y[9:0]} point data.
- wr_exp  in  1  expected is_inside; stored only when wr_pt==0.
- num_cases  in  CASE_W+1  number of cases to run, 1..MAX_CASES; sampled on start.
- start  in  1  one-cycle run request; accepted only in IDLE.
- X  out  10  point X to the receiver.
- Y  out  10  point Y to the receiver.
- dut_rst  out  1  active-high reset pulse to the receiver.
- valid  in  1  receiver result strobe.
- is_inside  in  1  receiver result.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse when the run completes.
- pass_cnt  out  CASE_W+1  number of matching results.
- fail_cnt  out  CASE_W+1  number of mismatches, plus timeouts when enabled.
- first_fail  out  CASE_W  index of the first failing case; valid while fail_cnt != 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - X, Y, dut_rst, busy, done, pass_cnt, fail_cnt and first_fail all go to 0.
  - Case memory is not cleared.
- Writes:
  - Memory writes are accepted in any state.
  - A write to the case currently streaming corrupts that run; this is the user's responsibility.
  - num_cases==0 or num_cases>MAX_CASES: start is ignored.
- States: IDLE, RST_DUT, SEND, WAIT, DONE.
- IDLE:
  - X and Y are 0.
  - start (with a legal num_cases) clears pass_cnt, fail_cnt and first_fail, sets case index c=0, sets busy=1, and goes to RST_DUT.
- RST_DUT:
  - dut_rst=1 for exactly one cycle, then SEND with point counter k=0.
- SEND:
  - Seven consecutive cycles, k = 0..6.
  - In the cycle with counter k, X/Y = point k of case c. Outputs are registered and glitch-free.
  - After k==6 go to WAIT; X and Y return to 0.
- WAIT:
  - Holds until valid==1.
  - In the valid cycle, compare is_inside against exp[c]:
    - Match: pass_cnt++.
    - Mismatch: fail_cnt++; if this is the first failure, first_fail=c.
  - If c==num_cases-1, go to DONE.
  - Otherwise c++ and go directly to SEND. The new object point is driven in the cycle after valid, matching the receiver's one-cycle post-result return to its load state. No dut_rst is issued between cases.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - Counters hold until the next accepted start.
- valid outside WAIT is ignored and not counted.
- start while busy is ignored.
- Counters never wrap: a maximum of MAX_CASES counts fits in CASE_W+1 bits.
- Reset mid-run aborts to IDLE with all outputs at their reset values. dut_rst is not pulsed on reset.
- Latency per case: 7 SEND cycles plus the receiver's processing time. The first case adds one RST_DUT cycle.

Optional Feature:
- Macro: GEOFENCE_DRV_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without valid, the case is scored as a fail: fail_cnt++, first_fail is updated if this is the first failure.
  - Then, if cases remain, c++ and go to RST_DUT to realign the receiver; otherwise go to DONE.
  - valid in the same cycle the count reaches TIMEOUT takes priority and is scored normally.
- Undefined:
  - WAIT holds indefinitely for valid.
  - No wait counter exists.

Test Plan:
- Load case 0: object (500,500); hexagon (600,500), (550,587), (450,587), (400,500), (450,413), (550,413); exp=1. start with num_cases=1; receiver returns valid with is_inside=1 -> pass_cnt=1, fail_cnt=0, one done pulse, and X/Y sequence matches the seven points on consecutive cycles after dut_rst.
- Same hexagon with object (0,0), exp=1; receiver returns is_inside=0 -> fail_cnt=1, first_fail=0.
- Three cases with exp 1,0,1, receiver answers all correct -> pass_cnt=3. The object of case n+1 appears exactly one cycle after case n's valid; only one dut_rst per run.
- valid pulsed during SEND and start pulsed while busy -> no counter change and run unaffected. num_cases=0 start -> remains IDLE, busy=0.
- Assert reset during WAIT of case 1 of 3 -> next cycle state is IDLE, all outputs 0; a restart completes normally.
- With GEOFENCE_DRV_TIMEOUT_EN and TIMEOUT=64, receiver never answers case 0 of 2 -> after 64 WAIT cycles fail_cnt=1, first_fail=0, dut_rst pulses, and case 1 is then scored normally.
